// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH,
//   processed LSB first, one bit per clock, behind a start/ready/done
//   handshake. Trades latency (WIDTH+2 cycles per op) for a single
//   full-subtractor cell.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   begin an operation (only honoured while ready=1)
//   a, b    minuend / subtrahend, captured on the accepted start edge
//   bin     borrow-in, captured on the accepted start edge
//   ready   idle, able to accept start
//   diff    result, updated only when an operation completes
//   borrow  borrow-out (1 iff a < b + bin)
//   done    one-cycle pulse while diff/borrow hold a fresh result
//   ovf     (only with SUB_OVERFLOW_EN) signed overflow of a - b - bin
//
// Build option
//   SUB_OVERFLOW_EN  adds the ovf output and its flop.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;

  // Full-subtractor cell on the current LSBs
  logic a_lsb, b_lsb, d, br_nxt, last;
  assign a_lsb  = a_sr[0];
  assign b_lsb  = b_sr[0];
  assign d      = a_lsb ^ b_lsb ^ br;
  assign br_nxt = (~a_lsb & b_lsb) | (~(a_lsb ^ b_lsb) & br);
  assign last   = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand/result shift registers, running borrow, counter.
  // diff/borrow are loaded only on the final SHIFT edge so partial
  // results never appear on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= br_nxt;
          if (last) begin
            diff   <= {d, res_sr[WIDTH-1:1]};
            borrow <= br_nxt;
`ifdef SUB_OVERFLOW_EN
            // br here is the borrow into the MSB, br_nxt the borrow out
            ovf    <= br ^ br_nxt;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, borrow, done;
  logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .diff  (diff),
    .borrow(borrow),
    .done  (done)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  // Reference state: what diff/borrow/ovf should currently hold
  int exp_diff = 0, exp_bor = 0, exp_ovf = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference for one operation
  task automatic model(input int ta, input int tb_, input int tbin);
    int sa, sb, r;
    exp_diff = (ta - tb_ - tbin) & MASK;
    exp_bor  = (ta < tb_ + tbin) ? 1 : 0;
    sa = (ta >= HALF) ? ta - (1 << W) : ta;
    sb = (tb_ >= HALF) ? tb_ - (1 << W) : tb_;
    r  = sa - sb - tbin;
    exp_ovf = (r < -HALF || r > HALF - 1) ? 1 : 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_diff"}, int'(diff), exp_diff);
    chk({tag, "_borrow"}, int'(borrow), exp_bor);
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, int'(ovf), exp_ovf);
`endif
  endtask

  // One operation from IDLE. With noise set, inputs (including start)
  // are scrambled while busy; none of it may affect the result.
  task automatic do_op(input string tag, input int ta, input int tb_,
                       input int tbin, input bit noise);
    int n;
    a = W'(ta); b = W'(tb_); bin = tbin[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_accepted"}, int'(ready), 0);
    n = 0;
    while (!done && n < 3 * W) begin
      chk({tag, "_busy_ready"}, int'(ready), 0);
      chk({tag, "_hold_diff"}, int'(diff), exp_diff);
      if (noise) begin
        start = 1'($urandom); a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      tick();
      n++;
    end
    model(ta, tb_, tbin);
    chk({tag, "_latency"}, n, W);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_done_ready"}, int'(ready), 0);
    chk_outs(tag);
    start = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_ready"}, int'(ready), 1);
    chk_outs({tag, "_held"});
  endtask

  initial begin
    int n;
    // Reset with start asserted: nothing may begin
    rst_n = 1'b0; start = 1'b1; a = 4'b0101; b = 4'b0011;
    tick(); tick();
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk_outs("rst");
    start = 1'b0; rst_n = 1'b1;
    tick();
    chk("rst_no_op", int'(ready), 1);

    // Directed vectors
    do_op("basic", 5, 3, 0, 1'b0);
    do_op("under0", 0, 1, 0, 1'b0);
    do_op("under1", 15, 15, 1, 1'b0);
    do_op("bin_a", 10, 5, 1, 1'b0);
    do_op("ovf_pos", 7, 15, 0, 1'b0);
    do_op("busy", 5, 3, 0, 1'b1);

    // Abort on the 3rd SHIFT edge
    a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_diff = 0; exp_bor = 0; exp_ovf = 0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    chk_outs("abort");
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort_no_done", int'(done), 0);
    end
    do_op("after_abort", 8, 1, 0, 1'b0);

    // start held high: back-to-back ops of W+2 cycles each
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("b2b_first", n, W + 1);
    n = 0;
    do begin tick(); n++; end while (!done && n < 20);
    chk("b2b_period", n, W + 2);
    start = 1'b0;
    model(5, 3, 0);
    chk_outs("b2b");
    tick();

    // Randomized operations with noise while busy
    for (int i = 0; i < 40; i++)
      do_op("rand", int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, 1)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
